uart_rx_fifo: RTL and testbench

Receive-side byte FIFO between the UART `async_receiver` and the CPU-facing UART register block. It absorbs bursts of received bytes, such as pasted text or WozMon hex dumps at 115200 baud, while the 6502 polls 0xD011 and 0xD010. It also drives the CTS flow-control line with hysteresis. Without it, any byte arriving before the CPU has read the previous one is lost.

---
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with first-word-fall-through read and CTS hysteresis
// Absorbs bursts from the UART receiver; cts high asks the sender to pause.
module uart_rx_fifo #(
  parameter int AW     = 4,
  parameter int CTS_HI = 12,
  parameter int CTS_LO = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_stb,
  input  logic [7:0]    wr_data,
  input  logic          rd_ack,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          cts
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] HI_C    = (AW+1)'(CTS_HI);
  localparam logic [AW:0] LO_C    = (AW+1)'(CTS_LO);

  typedef enum logic {OPEN, THROTTLE} cts_state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          cts_q, cts_d;
  cts_state_e    state_q, state_d;
  logic          rd_acc, wr_acc, drop;

  always_comb begin
    rd_acc = rd_ack && (count_q != '0);
    // A read in the same cycle frees the slot, so a full FIFO can still take the byte.
    wr_acc = wr_stb && ((count_q != DEPTH_C) || rd_acc);
    drop   = wr_stb && !wr_acc;

    wp_d = wr_acc ? wp_q + AW'(1) : wp_q;
    rp_d = rd_acc ? rp_q + AW'(1) : rp_q;

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    state_d = state_q;
    case (state_q)
      OPEN:     if (count_q >= HI_C) state_d = THROTTLE;
      THROTTLE: if (count_q <= LO_C) state_d = OPEN;
      default:  state_d = OPEN;
    endcase
    cts_d = (state_d == THROTTLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= OPEN;
      cts_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cts_q   <= cts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wp_q] <= wr_data;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rp_q] : 8'h00;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign overflow = ovf_q;
  assign cts      = cts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
// Queue model updated per clock; negedge compare plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int HI = 12;
  localparam int LO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_stb = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        rd_ack = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [AW:0] count;
  logic        full;
  logic        overflow;
  logic        cts;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_cts = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.AW(AW), .CTS_HI(HI), .CTS_LO(LO)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_data(wr_data), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
    .overflow(overflow), .ovf_clr(ovf_clr), .cts(cts)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, then advance the model by the documented FIFO rules.
  task automatic cyc(input logic r, input logic w, input logic [7:0] d,
                     input logic rd, input logic clr);
    int  pre;
    bit  racc, wacc;
    rst = r; wr_stb = w; wr_data = d; rd_ack = rd; ovf_clr = clr;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_cts = 1'b0;
    end else begin
      pre  = q.size();
      racc = rd && (pre != 0);
      wacc = w && ((pre < DEPTH) || racc);
      if (clr) m_ovf = 1'b0;
      if (w && !wacc) m_ovf = 1'b1;
      if (pre >= HI) m_cts = 1'b1;
      else if (pre <= LO) m_cts = 1'b0;
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
    end
    #1;
    rst = 1'b0; wr_stb = 1'b0; rd_ack = 1'b0; ovf_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, q.size() != 0});
      chk("rd_data", {24'd0, rd_data}, {24'd0, (q.size() != 0) ? q[0] : 8'h00});
      chk("count", {27'd0, count}, q.size());
      chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("cts", {31'd0, cts}, {31'd0, m_cts});
    end
  end

  initial begin
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    checking = 1'b1;
    chk("reset_count", {27'd0, count}, 0);
    chk("reset_valid", {31'd0, rd_valid}, 0);
    chk("reset_data", {24'd0, rd_data}, 8'h00);

    // single byte
    cyc(0, 1, 8'hC1, 0, 0);
    chk("single_valid", {31'd0, rd_valid}, 1);
    chk("single_data", {24'd0, rd_data}, 8'hC1);
    chk("single_count", {27'd0, count}, 1);
    cyc(0, 0, 8'h00, 1, 0);
    chk("single_rd_valid", {31'd0, rd_valid}, 0);
    chk("single_rd_data", {24'd0, rd_data}, 8'h00);

    // empty corners
    cyc(0, 0, 8'h00, 1, 0);
    chk("empty_ack_count", {27'd0, count}, 0);
    cyc(0, 1, 8'h55, 1, 0);
    chk("empty_wr_rd_count", {27'd0, count}, 1);
    chk("empty_wr_rd_data", {24'd0, rd_data}, 8'h55);
    cyc(0, 0, 8'h00, 1, 0);

    // fill and wrap
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'(i), 0, 0);
    chk("fill_full", {31'd0, full}, 1);
    chk("fill_count", {27'd0, count}, 16);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("wrap_seq", {24'd0, rd_data}, 8'h04 + i);
      cyc(0, 0, 8'h00, 1, 0);
    end
    chk("wrap_empty", {31'd0, rd_valid}, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);

    // cts hysteresis
    for (int i = 0; i < 11; i++) cyc(0, 1, 8'(8'h20 + i), 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("cts_11", {31'd0, cts}, 0);
    cyc(0, 1, 8'h2B, 0, 0);
    chk("cts_12_lag", {31'd0, cts}, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("cts_12", {31'd0, cts}, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("cts_5_count", {27'd0, count}, 5);
    chk("cts_5", {31'd0, cts}, 1);
    cyc(0, 0, 8'h00, 1, 0);
    chk("cts_4_lag", {31'd0, cts}, 1);
    cyc(0, 0, 8'h00, 0, 0);
    chk("cts_4", {31'd0, cts}, 0);

    // overflow
    cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'(i), 0, 0);
    cyc(0, 1, 8'hAA, 0, 0);
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_count", {27'd0, count}, 16);
    chk("ovf_head", {24'd0, rd_data}, 8'h00);
    cyc(0, 0, 8'h00, 0, 1);
    chk("ovf_clr", {31'd0, overflow}, 0);
    cyc(0, 1, 8'hBB, 1, 0);
    chk("full_wr_rd_count", {27'd0, count}, 16);
    chk("full_wr_rd_ovf", {31'd0, overflow}, 0);
    cyc(0, 1, 8'hCC, 0, 1);
    chk("ovf_set_wins", {31'd0, overflow}, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) chk("drain_first", {24'd0, rd_data}, 8'h01);
      if (i == 15) chk("drain_last_bb", {24'd0, rd_data}, 8'hBB);
      cyc(0, 0, 8'h00, 1, 0);
    end

    // reset mid-traffic
    for (int i = 0; i < 7; i++) cyc(0, 1, 8'(8'h40 + i), 0, 0);
    chk("pre_rst_count", {27'd0, count}, 7);
    chk("pre_rst_ovf", {31'd0, overflow}, 1);
    cyc(1, 1, 8'h77, 0, 0);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_valid", {31'd0, rd_valid}, 0);
    chk("rst_data", {24'd0, rd_data}, 8'h00);
    chk("rst_cts", {31'd0, cts}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
